// File: rtl/seq_alu.sv
// seq_alu: registered eight-operation ALU with an iterative shift-add multiply.
// It holds one operation at a time. A result stays on s and the flags until
// the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its valid signal and payload stable until that
// transfer. The block never accepts a new operation in the same cycle that it
// hands over a result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand/op presented
//   in_ready   block can accept (IDLE only)
//   a, b       operands (WIDTH bits), sampled only at the accept edge
//   op         operation select (3 bits)
//   out_valid  result and flags valid (OUT state)
//   out_ready  consumer takes the result
//   s          result
//   eq         captured a == captured b
//   cary       carry (ADD) / borrow (SUB), otherwise 0
//   of         signed overflow (ADD/SUB), otherwise 0
//   zero       s == 0
//   busy       multiply in progress
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             eq,
    output logic             cary,
    output logic             of,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL = 3'b110;

    state_t state;
    state_t state_next;

    logic             accept;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             eq_pend;
    logic             last_iter;
    logic [WIDTH-1:0] acc_step;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] res;
    logic             res_cary;
    logic             res_of;

    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    // The multiply step is shared by the accumulator update and the final load.
    // This lets the last iteration go straight into s without an extra cycle.
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;

    assign add_full  = {1'b0, a} + {1'b0, b};
    assign sub_full  = {1'b0, a} - {1'b0, b};

    // Single-cycle operations
    always_comb begin
        res      = '0;
        res_cary = 1'b0;
        res_of   = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: res = a ^ b;
            3'b011: begin
                res      = add_full[WIDTH-1:0];
                res_cary = add_full[WIDTH];
                res_of   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            3'b100: begin
                res      = sub_full[WIDTH-1:0];
                // The top bit of the extended difference is the unsigned borrow.
                res_cary = sub_full[WIDTH];
                res_of   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            3'b101: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b111: res = ~(a | b);
            default: res = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (op == OP_MUL) ? S_MUL : S_OUT;
                end
            end
            S_MUL: begin
                if (last_iter) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: outputs, decoded from the state register only
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state == S_MUL);
        out_valid = (state == S_OUT);
    end

    // Datapath: result, flags and multiply registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s       <= '0;
            eq      <= 1'b0;
            cary    <= 1'b0;
            of      <= 1'b0;
            zero    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            eq_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mcand   <= a;
                            mplier  <= b;
                            acc     <= '0;
                            cnt     <= '0;
                            // The operands get shifted away during the multiply,
                            // so remember eq now.
                            eq_pend <= (a == b);
                        end else begin
                            s    <= res;
                            eq   <= (a == b);
                            cary <= res_cary;
                            of   <= res_of;
                            zero <= (res == '0);
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        s    <= acc_step;
                        eq   <= eq_pend;
                        cary <= 1'b0;
                        of   <= 1'b0;
                        zero <= (acc_step == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven and scoreboard-checked bench for seq_alu (WIDTH=32).
module tb_seq_alu;

    localparam int W  = 32;
    localparam int EW = W + 4;  // {s, eq, cary, of, zero}

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         eq;
    logic         cary;
    logic         of;
    logic         zero;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] s;
        logic         eq;
        logic         cary;
        logic         of;
        logic         zero;
    } vec_t;

    vec_t vecs[16];

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .eq        (eq),
        .cary      (cary),
        .of        (of),
        .zero      (zero),
        .busy      (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Independent reference model: wide arithmetic, signed range checks for overflow
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic [2:0] mop);
        logic [W-1:0]  r;
        logic          c;
        logic          o;
        logic [63:0]   p;
        longint        sa;
        longint        sb;
        longint        sr;
        r  = '0;
        c  = 1'b0;
        o  = 1'b0;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            3'd0: r = ma & mb;
            3'd1: r = ma | mb;
            3'd2: r = ma ^ mb;
            3'd3: begin
                p  = {32'd0, ma} + {32'd0, mb};
                r  = p[W-1:0];
                c  = p[W];
                sr = sa + sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd4: begin
                r  = ma - mb;
                c  = (ma < mb);
                sr = sa - sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: begin
                p = {32'd0, ma} * {32'd0, mb};
                r = p[W-1:0];
            end
            default: r = ~(ma | mb);
        endcase
        return {r, (ma == mb), c, o, (r == '0)};
    endfunction

    // Scoreboard: compare whenever a result transfer is about to happen
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h, expected no output", {s, eq, cary, of, zero});
            end else begin
                e = exp_q.pop_front();
                check("result", 64'({s, eq, cary, of, zero}), 64'(e));
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 64'(guard), 64'(0));
    endtask

    // Issue one op, check latency/busy, then consume after 'hold' stall cycles
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] vop,
                          input logic [EW-1:0] e, input int hold);
        int cyc;
        logic ok_busy;
        wait_ready();
        a        = va;
        b        = vb;
        op       = vop;
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs: only the accept edge may matter
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom_range(0, 7));
        cyc     = 0;
        ok_busy = 1'b1;
        while (!out_valid && cyc < 100) begin
            if (vop == 3'b110 && (!busy || in_ready)) ok_busy = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), (vop == 3'b110) ? 64'(W) : 64'(0));
        if (vop == 3'b110) check("mul_busy", 64'(ok_busy), 64'(1));
        repeat (hold) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'(0));
    endtask

    initial begin
        vecs[0]  = '{32'hFFFF0000, 32'h0000FFFF, 3'b010, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b011, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 3'b011, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h00000005, 32'h00000007, 3'b100, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h00000001, 3'b100, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'd12345,    32'd6789,     3'b110, 32'h04FED79D, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 3'b000, 32'h05050505, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 3'b000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 3'b001, 32'hAFAFAFAF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h00000000, 32'h00000000, 3'b111, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h00000007, 32'h00000007, 3'b100, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{32'h80000000, 32'h80000000, 3'b011, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_s",         64'(s),         64'(0));
        check("rst_flags",     64'({eq, cary, of, zero}), 64'(0));

        // Table of directed vectors
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op,
                   {vecs[i].s, vecs[i].eq, vecs[i].cary, vecs[i].of, vecs[i].zero}, i % 3);
        end

        // Backpressure: hold the result, with a new request pending meanwhile
        wait_ready();
        a = 32'h7FFFFFFF; b = 32'h00000001; op = 3'b011; in_valid = 1'b1;
        exp_q.push_back({32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        a = 32'd3; b = 32'd4; op = 3'b011;  // held request, must wait
        for (int i = 0; i < 5; i++) begin
            check("bp_s",         64'(s), 64'h80000000);
            check("bp_flags",     64'({eq, cary, of, zero}), 64'b0010);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready",  64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        exp_q.push_back({32'd7, 1'b0, 1'b0, 1'b0, 1'b0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'(0));
        check("bp_release_ready", 64'(in_ready),  64'(1));
        @(posedge clk); #1;  // held request accepted here
        in_valid = 1'b0;
        check("bp_next_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a multiply: no result may appear
        wait_ready();
        a = 32'd12345; b = 32'd6789; op = 3'b110; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_out_valid", 64'(out_valid), 64'(0));
        check("mrst_busy",      64'(busy),      64'(0));
        check("mrst_in_ready",  64'(in_ready),  64'(1));
        check("mrst_s",         64'(s),         64'(0));
        out_ready = 1'b1;
        repeat (40) @(posedge clk);  // any stray output would hit the scoreboard
        #1;
        out_ready = 1'b0;
        run_op(32'd1, 32'd2, 3'b011, {32'd3, 1'b0, 1'b0, 1'b0, 1'b0}, 0);

        // Random operations against the model
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [2:0]   rop;
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rop = 3'($urandom_range(0, 7));
            run_op(ra, rb, rop, model(ra, rb, rop), $urandom_range(0, 2));
        end

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational xor ALU.
- Supports eight operations, including an iterative shift-add multiply.
- Uses a valid/ready handshake on both input and output, so it sits directly between the operand-issue logic and the result-writeback stage.
- Single-entry design: one operation in flight; results are held until consumed.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept; transfer on in_valid && in_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result; transfer on out_valid && out_ready.
- s  output  WIDTH  result.
- eq  output  1  a == b (captured operands).
- cary  output  1  carry/borrow.
- of  output  1  signed overflow.
- zero  output  1  s == 0.
- busy  output  1  multiply in progress.

Behaviour:
- All outputs are registered. Reset (synchronous, rst sampled high at a clk edge) gives:
  - state=IDLE, in_ready=1, out_valid=0, busy=0;
  - s=0, eq=0, cary=0, of=0, zero=0;
  - multiply registers and counter cleared.
- Reset overrides everything, including mid-multiply and a held result. In-flight work is discarded with no output.
- States:
  - IDLE: in_ready=1. On accept at edge k:
    - op != 110: compute, load s/flags, go to OUT. out_valid=1 in the cycle after edge k.
    - op == 110: capture operands, counter=0, go to MUL.
  - MUL: in_ready=0, busy=1.
    - Each edge: if the multiplier LSB is 1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
    - After WIDTH iterations (edge k+WIDTH), load s=acc and flags, go to OUT.
    - out_valid first high in the cycle after edge k+WIDTH.
  - OUT: out_valid=1, in_ready=0. s and all flags are held stable while out_ready=0. On out_ready=1, go to IDLE; out_valid=0 the next cycle.
- No same-cycle accept while in OUT. Maximum throughput is one op per 2 cycles for simple ops and one per WIDTH+2 cycles for MUL.
- Opcodes (WIDTH-bit, wrap-around arithmetic):
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 ADD: s = a + b; cary = carry out of bit WIDTH-1; of = (a[msb]==b[msb]) && (s[msb]!=a[msb]).
  - 100 SUB: s = a - b; cary = borrow (a < b unsigned); of = (a[msb]!=b[msb]) && (s[msb]!=a[msb]).
  - 101 SLT: s = {0..., a<b signed}.
  - 110 MUL: s = low WIDTH bits of a*b.
  - 111 NOR
- cary and of are 0 for every op other than ADD and SUB.
- eq is always computed from the captured a and b.
- zero always reflects the loaded s.
- in_valid while in_ready=0 is ignored. The presenter must hold its request until the transfer.
- a, b and op are sampled only at the accept edge; later changes have no effect on the result.

Test Plan (WIDTH=32):
- XOR: a=FFFF0000, b=0000FFFF, op=010, accept at edge k -> out_valid cycle after k; s=FFFFFFFF, eq=0, zero=0, cary=0, of=0. Repeat with a=b=FFFFFFFF -> s=0, eq=1, zero=1.
- ADD wrap and overflow:
  - FFFFFFFF+00000001 -> s=0, cary=1, of=0, zero=1.
  - 7FFFFFFF+00000001 -> s=80000000, cary=0, of=1.
- SUB/SLT:
  - 5-7 -> s=FFFFFFFE, cary=1, of=0.
  - 80000000-1 -> s=7FFFFFFF, of=1.
  - SLT a=FFFFFFFF, b=1 -> s=1.
- MUL: a=12345, b=6789 -> busy=1 for 32 cycles, in_ready=0 throughout; out_valid 32 cycles after accept; s=04FED79D, cary=0, of=0. Also FFFFFFFF*FFFFFFFF -> s=00000001.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> s and flags unchanged, in_ready=0, in_valid ignored; release -> IDLE, then next op accepted.
- Reset mid-multiply: assert rst at iteration 10 -> next cycle out_valid=0, busy=0, in_ready=1, s=0; no result is emitted and the following ADD completes normally.
